// File: rtl/pix_fifo_ctrl.sv
// Synchronous pixel FIFO with load/req_out handshake, flush, watermarks and error pulses.
// Optional macro PIX_FIFO_ERR_CNT_EN adds a saturating 8-bit error counter output err_cnt.
module pix_fifo_ctrl #(
    parameter int PIX_WIDTH = 16,
    parameter int DEPTH     = 8,
    parameter int AF_LEVEL  = DEPTH - 2,
    parameter int AE_LEVEL  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   load,
    input  logic [PIX_WIDTH-1:0]   pix_in,
    input  logic                   req_out,
    output logic [PIX_WIDTH-1:0]   pix_out,
    output logic                   ack_out,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic                   overflow,
    output logic                   underflow
`ifdef PIX_FIFO_ERR_CNT_EN
    ,
    output logic [7:0]             err_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int FW = PW + 1;

    logic [PIX_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]        fill_q, fill_d;
    logic [PIX_WIDTH-1:0] pix_q, pix_d;
    logic                 ack_q, ack_d, ovf_q, ovf_d, unf_q, unf_d;
    logic                 write_ok, read_ok, is_full, is_empty;

    assign is_full  = (fill_q == FW'(DEPTH));
    assign is_empty = (fill_q == '0);

    // A read frees a slot in the same cycle, so a full FIFO can still accept a write.
    always_comb begin
        read_ok  = req_out && !is_empty && !flush;
        write_ok = load && (!is_full || read_ok) && !flush;
        ovf_d    = load && !write_ok && !flush;
        unf_d    = req_out && !read_ok && !flush;
        ack_d    = read_ok;
        pix_d    = read_ok ? mem_q[rd_ptr_q] : pix_q;
        wr_ptr_d = write_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = read_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
        fill_d   = fill_q;
        case ({write_ok, read_ok})
            2'b10:   fill_d = fill_q + FW'(1);
            2'b01:   fill_d = fill_q - FW'(1);
            default: fill_d = fill_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            pix_q    <= '0;
            ack_q    <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            pix_q    <= pix_d;
            ack_q    <= ack_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is deliberately left out of reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (write_ok) mem_q[wr_ptr_q] <= pix_in;
    end

`ifdef PIX_FIFO_ERR_CNT_EN
    logic [7:0] err_q, err_d;
    logic [8:0] err_sum;

    always_comb begin
        err_sum = {1'b0, err_q} + {7'd0, ovf_d} + {7'd0, unf_d};
        err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= '0;
        else        err_q <= err_d;
    end

    assign err_cnt = err_q;
`endif

    assign pix_out      = pix_q;
    assign ack_out      = ack_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign fill_level   = fill_q;
    assign full         = is_full;
    assign empty        = is_empty;
    assign almost_full  = (fill_q >= FW'(AF_LEVEL));
    assign almost_empty = (fill_q <= FW'(AE_LEVEL));

endmodule

// File: tb/tb_pix_fifo_ctrl.sv
// Self-checking bench for pix_fifo_ctrl: directed scenarios plus randomized traffic against a queue model.
module tb_pix_fifo_ctrl;
    localparam int PIX_WIDTH = 16;
    localparam int DEPTH     = 8;
    localparam int FW        = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 flush = 1'b0, load = 1'b0, req_out = 1'b0;
    logic [PIX_WIDTH-1:0] pix_in = '0;
    logic [PIX_WIDTH-1:0] pix_out;
    logic                 ack_out, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [FW-1:0]        fill_level;
`ifdef PIX_FIFO_ERR_CNT_EN
    logic [7:0]           err_cnt;
`endif

    pix_fifo_ctrl #(.PIX_WIDTH(PIX_WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush), .load(load), .pix_in(pix_in),
        .req_out(req_out), .pix_out(pix_out), .ack_out(ack_out), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .fill_level(fill_level), .overflow(overflow), .underflow(underflow)
`ifdef PIX_FIFO_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [PIX_WIDTH-1:0] q[$];
    logic [PIX_WIDTH-1:0] exp_pix;
    logic                 exp_ack, exp_ovf, exp_unf;
    int                   exp_err;
    int                   checks = 0, errors = 0;

    task automatic model_reset();
        q.delete();
        exp_pix = '0; exp_ack = 0; exp_ovf = 0; exp_unf = 0; exp_err = 0;
    endtask

    // Apply one cycle of stimulus; the model advances at the same edge from its pre-edge state.
    task automatic step(input logic ld, input logic [PIX_WIDTH-1:0] d, input logic rq, input logic fl);
        int  n;
        logic rd, wr;
        load = ld; pix_in = d; req_out = rq; flush = fl;
        @(posedge clk);
        n = q.size();
        if (fl) begin
            q.delete();
            exp_ack = 0; exp_ovf = 0; exp_unf = 0;
        end else begin
            rd = rq && (n > 0);
            wr = ld && ((n < DEPTH) || rd);
            exp_ack = rd;
            if (rd) exp_pix = q.pop_front();
            if (wr) q.push_back(d);
            exp_ovf = ld && !wr;
            exp_unf = rq && !rd;
            exp_err = exp_err + int'(exp_ovf) + int'(exp_unf);
            if (exp_err > 255) exp_err = 255;
        end
        #1;
        load = 0; req_out = 0; flush = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        model_reset();
        checks++;
        if ({ack_out, overflow, underflow, full, empty, almost_full, almost_empty} !== 7'b0000101) begin
            errors++; $display("FAIL reset_flags: got %b exp %b",
                {ack_out, overflow, underflow, full, empty, almost_full, almost_empty}, 7'b0000101);
        end
        checks++;
        if (fill_level !== 4'd0 || pix_out !== 16'h0) begin
            errors++; $display("FAIL reset_data: got fill=%0d pix=%h exp fill=0 pix=0000", fill_level, pix_out);
        end
`ifdef PIX_FIFO_ERR_CNT_EN
        checks++;
        if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d exp 0", err_cnt); end
`endif
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [PIX_WIDTH-1:0] vals [3];
        vals[0] = 16'h50ff; vals[1] = 16'h308e; vals[2] = 16'h08f1;
        for (int i = 0; i < 3; i++) step(1, vals[i], 0, 0);
        checks++;
        if (fill_level !== 4'd3) begin errors++; $display("FAIL basic_fill: got %0d exp 3", fill_level); end
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 1, 0);
            checks++;
            if (ack_out !== 1'b1 || pix_out !== vals[i]) begin
                errors++; $display("FAIL basic_read%0d: got ack=%b pix=%h exp ack=1 pix=%h", i, ack_out, pix_out, vals[i]);
            end
        end
        step(0, '0, 0, 0);
        checks++;
        if (empty !== 1'b1 || ack_out !== 1'b0) begin
            errors++; $display("FAIL basic_end: got empty=%b ack=%b exp empty=1 ack=0", empty, ack_out);
        end
    endtask

    task automatic test_full_overflow();
        logic [PIX_WIDTH-1:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            step(1, PIX_WIDTH'($urandom), 0, 0);
            checks++;
            if (almost_full !== (i + 1 >= 6)) begin
                errors++; $display("FAIL af_fill%0d: got %b exp %b", i + 1, almost_full, (i + 1 >= 6));
            end
        end
        checks++;
        if (full !== 1'b1 || fill_level !== 4'd8) begin
            errors++; $display("FAIL full_flag: got full=%b fill=%0d exp full=1 fill=8", full, fill_level);
        end
        step(1, 16'hdead, 0, 0);
        checks++;
        if (overflow !== 1'b1 || fill_level !== 4'd8) begin
            errors++; $display("FAIL overflow: got ovf=%b fill=%0d exp ovf=1 fill=8", overflow, fill_level);
        end
        step(0, '0, 0, 0);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_pulse: got %b exp 0", overflow); end
        for (int i = 0; i < DEPTH; i++) begin
            v = q[0];
            step(0, '0, 1, 0);
            checks++;
            if (ack_out !== 1'b1 || pix_out !== v) begin
                errors++; $display("FAIL drain%0d: got ack=%b pix=%h exp ack=1 pix=%h", i, ack_out, pix_out, v);
            end
        end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b exp 1", empty); end
    endtask

    task automatic test_empty_rw();
        step(1, 16'h2575, 1, 0);
        checks++;
        if (underflow !== 1'b1 || ack_out !== 1'b0 || fill_level !== 4'd1) begin
            errors++; $display("FAIL empty_rw: got unf=%b ack=%b fill=%0d exp unf=1 ack=0 fill=1",
                               underflow, ack_out, fill_level);
        end
        step(0, '0, 1, 0);
        checks++;
        if (ack_out !== 1'b1 || pix_out !== 16'h2575 || underflow !== 1'b0) begin
            errors++; $display("FAIL empty_rw_read: got ack=%b pix=%h unf=%b exp ack=1 pix=2575 unf=0",
                               ack_out, pix_out, underflow);
        end
    endtask

    task automatic test_full_rw();
        logic [PIX_WIDTH-1:0] oldest, last;
        for (int i = 0; i < DEPTH; i++) step(1, PIX_WIDTH'($urandom), 0, 0);
        oldest = q[0];
        step(1, 16'hafe1, 1, 0);
        checks++;
        if (ack_out !== 1'b1 || pix_out !== oldest || overflow !== 1'b0 || fill_level !== 4'd8) begin
            errors++; $display("FAIL full_rw: got ack=%b pix=%h ovf=%b fill=%0d exp ack=1 pix=%h ovf=0 fill=8",
                               ack_out, pix_out, overflow, fill_level, oldest);
        end
        for (int i = 0; i < DEPTH; i++) step(0, '0, 1, 0);
        last = pix_out;
        checks++;
        if (last !== 16'hafe1 || empty !== 1'b1) begin
            errors++; $display("FAIL full_rw_last: got pix=%h empty=%b exp pix=afe1 empty=1", last, empty);
        end
    endtask

    task automatic test_flush();
        logic [PIX_WIDTH-1:0] held;
        for (int i = 0; i < 5; i++) step(1, PIX_WIDTH'($urandom), 0, 0);
        held = pix_out;
        step(1, 16'h1234, 1, 1);
        checks++;
        if (fill_level !== 4'd0 || empty !== 1'b1 || ack_out !== 1'b0 ||
            overflow !== 1'b0 || underflow !== 1'b0 || pix_out !== held) begin
            errors++; $display("FAIL flush: got fill=%0d empty=%b ack=%b ovf=%b unf=%b pix=%h exp 0 1 0 0 0 %h",
                               fill_level, empty, ack_out, overflow, underflow, pix_out, held);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step(1, PIX_WIDTH'($urandom_range(1, 16'hffff)), 0, 0);
        step(1, 16'h7777, 1, 0);
        load = 1; req_out = 1; pix_in = 16'h5555;
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({ack_out, overflow, underflow, full, empty, almost_full, almost_empty} !== 7'b0000101 ||
            fill_level !== 4'd0 || pix_out !== 16'h0) begin
            errors++; $display("FAIL async_reset: got flags=%b fill=%0d pix=%h exp flags=0000101 fill=0 pix=0000",
                {ack_out, overflow, underflow, full, empty, almost_full, almost_empty}, fill_level, pix_out);
        end
`ifdef PIX_FIFO_ERR_CNT_EN
        checks++;
        if (err_cnt !== 8'd0) begin errors++; $display("FAIL async_reset_err: got %0d exp 0", err_cnt); end
`endif
        load = 0; req_out = 0;
        #2 reset = 1'b1;
        step(0, '0, 1, 0);
        checks++;
        if (underflow !== 1'b1 || ack_out !== 1'b0 || pix_out !== 16'h0) begin
            errors++; $display("FAIL post_reset_read: got unf=%b ack=%b pix=%h exp unf=1 ack=0 pix=0000",
                               underflow, ack_out, pix_out);
        end
`ifdef PIX_FIFO_ERR_CNT_EN
        checks++;
        if (err_cnt !== 8'd1) begin errors++; $display("FAIL post_reset_err: got %0d exp 1", err_cnt); end
`endif
    endtask

    task automatic test_random();
        logic [6:0] exp_vec, got_vec;
        int         n, ld_pct;
        for (int i = 0; i < 400; i++) begin
            ld_pct = ((i / 40) % 2 == 0) ? 75 : 25;
            step($urandom_range(0, 99) < ld_pct, PIX_WIDTH'($urandom),
                 $urandom_range(0, 99) < (100 - ld_pct), $urandom_range(0, 39) == 0);
            n = q.size();
            exp_vec = {exp_ack, exp_ovf, exp_unf, n == DEPTH, n == 0, n >= DEPTH - 2, n <= 2};
            got_vec = {ack_out, overflow, underflow, full, empty, almost_full, almost_empty};
            checks++;
            if (got_vec !== exp_vec || fill_level !== FW'(n) || pix_out !== exp_pix) begin
                errors++; $display("FAIL random%0d: got flags=%b fill=%0d pix=%h exp flags=%b fill=%0d pix=%h",
                                   i, got_vec, fill_level, pix_out, exp_vec, n, exp_pix);
            end
`ifdef PIX_FIFO_ERR_CNT_EN
            checks++;
            if (err_cnt !== 8'(exp_err)) begin
                errors++; $display("FAIL random_err%0d: got %0d exp %0d", i, err_cnt, exp_err);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_overflow();
        test_empty_rw();
        test_full_rw();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pix_fifo_ctrl.md
Name: pix_fifo_ctrl

Overview:
Parametrised synchronous pixel FIFO that replaces the separate counter, controller and memory block arrangement with one block. It uses a `load`/`req_out` handshake and an `ack_out` read acknowledge. It adds configurable depth and width, flush, almost-full and almost-empty watermarks, and overflow/underflow flags. It sits between the rasteriser pixel stream and the Z-buffer compare stage.

Parameters:
PIX_WIDTH, 16, pixel data width in bits.
DEPTH, 8, number of entries; power of two, at least 2.
AF_LEVEL, DEPTH-2, almost_full asserts when fill_level >= AF_LEVEL.
AE_LEVEL, 2, almost_empty asserts when fill_level <= AE_LEVEL.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
flush  in  1  synchronous clear of pointers and fill count.
load  in  1  write request; pix_in is sampled at the clock edge.
pix_in  in  PIX_WIDTH  write data.
req_out  in  1  read request.
pix_out  out  PIX_WIDTH  read data, registered.
ack_out  out  1  one-cycle pulse: pix_out is valid this cycle.
full  out  1  fill_level == DEPTH.
empty  out  1  fill_level == 0.
almost_full  out  1  fill_level >= AF_LEVEL.
almost_empty  out  1  fill_level <= AE_LEVEL.
fill_level  out  $clog2(DEPTH)+1  current occupancy.
overflow  out  1  one-cycle pulse: a write was dropped.
underflow  out  1  one-cycle pulse: a read was rejected.

Behaviour:
- Reset (reset=0, asynchronous): write pointer, read pointer and fill_level = 0; pix_out = 0; ack_out, overflow, underflow = 0; empty=1, full=0, almost_empty=1, almost_full=0.
- Reset does not clear memory contents. Reset released mid-operation restarts from empty; any previously stored data is unreachable.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. fill_level is one bit wider so it can represent DEPTH.
- Accepted write: load=1 and (not full, or a read is accepted in the same cycle). mem[wr_ptr] <= pix_in; wr_ptr increments.
- Accepted read: req_out=1 and not empty (fill_level sampled before the edge). pix_out <= mem[rd_ptr] at that edge; ack_out=1 for the following cycle; rd_ptr increments.
- Read latency is exactly 1 cycle from the req_out edge to ack_out. pix_out holds its value when no read is accepted.
- Back-to-back reads give ack_out every cycle.
- Fill update: +1 on write only, -1 on read only, unchanged on both or neither.
- Full with load and req_out together: both accepted, fill stays DEPTH, no overflow.
- Empty with load and req_out together: write accepted, read rejected (no bypass), underflow=1, fill becomes 1.
- load while full with no accepted read: data dropped, overflow=1 for one cycle, state unchanged.
- req_out while empty: underflow=1 for one cycle, ack_out=0, pix_out unchanged.
- flush=1 has priority over load and req_out. Pointers and fill go to 0, ack_out=0, no overflow or underflow. pix_out holds its value. Memory is not cleared.
- Status outputs (full, empty, almost_full, almost_empty) are combinational decodes of the registered fill_level. No glitch path exists from load or req_out.
- No internal FSM beyond the pointers and counter: the controller is a two-flag decode (write_ok, read_ok) feeding the registered updates.

Optional Feature:
Macro PIX_FIFO_ERR_CNT_EN.
- When defined: adds output err_cnt [7:0], which increments once per overflow or underflow pulse and increments by 2 when both pulse in the same cycle. It saturates at 8'hFF, is cleared by reset, and is not cleared by flush.
- When not defined: the port and the counter are absent, and all other behaviour is identical.

Test Plan:
1. Reset, then load 16'h50ff, 16'h308e, 16'h08f1 on three consecutive cycles -> fill_level=3. Three req_out cycles -> ack_out pulses on three consecutive cycles with pix_out 50ff, 308e, 08f1; empty=1 at the end.
2. DEPTH=8: eight loads -> full=1, almost_full asserts at fill 6. A ninth load -> overflow=1 for one cycle, fill stays 8. Draining returns all eight values in order, so pointer wrap is verified.
3. Empty FIFO, req_out=1 with load=1 of 16'h2575 -> underflow=1, ack_out=0, fill=1. The next req_out returns 2575 with ack_out=1.
4. Full FIFO, load=1 of 16'hafe1 with req_out=1 -> oldest word read, afe1 stored, no overflow, fill stays 8. afe1 is the last word drained.
5. Fill 5 entries, then flush=1 together with load and req_out -> fill=0, empty=1, ack_out=0, no error pulses, pix_out unchanged.
6. Drive reset=0 asynchronously mid-burst, between clock edges -> all outputs reach their reset values before the next edge. After release, the FIFO reads as empty (underflow on req_out). With PIX_FIFO_ERR_CNT_EN defined, err_cnt reads 0 after reset and 1 after that underflow.
